// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: key event bundle from the scanner to user logic.
// key_code {row,col}, key_valid one-cycle pulse, key_down level while held.
interface keypad_scanner_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;

  modport master (output key_code, key_valid, key_down);
  modport slave  (input  key_code, key_valid, key_down);
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scan, debounce and key-code report.
// Ports: cp, rst_n (async low), KEY_ROW in, KEY_COL out, key_if master.
// Optional KEY_REPEAT_EN: auto-repeat key_valid while a key is held.
module keypad_scanner #(
  parameter int CLK_DIV        = 50000,
  parameter int DEBOUNCE_TICKS = 4
`ifdef KEY_REPEAT_EN
  ,
  parameter int REPEAT_DELAY   = 100,
  parameter int REPEAT_RATE    = 20
`endif
) (
  input  logic              cp,
  input  logic              rst_n,
  input  logic [3:0]        KEY_ROW,
  output logic [3:0]        KEY_COL,
  keypad_scanner_if.master  key_if
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_TICKS);

  typedef enum logic [1:0] {
    SCAN, PRESS_DB, HOLD, REL_DB
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    row_m_q, row_s_q;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    col_q, col_d;
  logic [1:0]    row_idx_q, row_idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic          down_q, down_d;
  logic          tick, hit, row_held;
  logic          do_accept, do_release;
  logic [1:0]    hit_row;

`ifdef KEY_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ?
                        REPEAT_DELAY : REPEAT_RATE;
  localparam int RW = $clog2(RMAX + 1);
  logic [RW-1:0] rpt_q, rpt_d;
`endif

  assign tick     = (div_q == DIV_LAST);
  assign div_d    = tick ? '0 : div_q + 1'b1;
  assign hit      = ~&row_s_q;
  assign row_held = ~row_s_q[row_idx_q];
  assign cnt_inc  = cnt_q + 1'b1;

  // lowest row index wins when several rows are low
  always_comb begin
    hit_row = 2'd0;
    priority case (1'b1)
      ~row_s_q[0]: hit_row = 2'd0;
      ~row_s_q[1]: hit_row = 2'd1;
      ~row_s_q[2]: hit_row = 2'd2;
      ~row_s_q[3]: hit_row = 2'd3;
      default:     hit_row = 2'd0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_idx_d  = row_idx_q;
    cnt_d      = cnt_q;
    code_d     = code_q;
    valid_d    = 1'b0;
    down_d     = down_q;
    do_accept  = 1'b0;
    do_release = 1'b0;
`ifdef KEY_REPEAT_EN
    rpt_d      = rpt_q;
`endif
    if (tick) begin
      unique case (state_q)
        SCAN: begin
          if (hit) begin
            row_idx_d = hit_row;
            cnt_d     = CW'(1);
            if (DEBOUNCE_TICKS == 1) do_accept = 1'b1;
            else state_d = PRESS_DB;
          end else begin
            col_d = col_q + 2'd1;
          end
        end
        PRESS_DB: begin
          if (row_held) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DB_LAST) do_accept = 1'b1;
          end else begin
            state_d = SCAN;
            col_d   = col_q + 2'd1;
          end
        end
        HOLD: begin
          if (!row_held) begin
            cnt_d = CW'(1);
            if (DEBOUNCE_TICKS == 1) do_release = 1'b1;
            else state_d = REL_DB;
          end else begin
`ifdef KEY_REPEAT_EN
            if (rpt_q == RW'(1)) begin
              valid_d = 1'b1;
              rpt_d   = RW'(REPEAT_RATE);
            end else begin
              rpt_d = rpt_q - 1'b1;
            end
`endif
          end
        end
        REL_DB: begin
          if (!row_held) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DB_LAST) do_release = 1'b1;
          end else begin
            state_d = HOLD;
`ifdef KEY_REPEAT_EN
            rpt_d   = RW'(REPEAT_DELAY);
`endif
          end
        end
        default: state_d = SCAN;
      endcase
    end
    if (do_accept) begin
      code_d  = {row_idx_d, col_q};
      valid_d = 1'b1;
      down_d  = 1'b1;
      state_d = HOLD;
`ifdef KEY_REPEAT_EN
      rpt_d   = RW'(REPEAT_DELAY);
`endif
    end
    if (do_release) begin
      down_d  = 1'b0;
      col_d   = col_q + 2'd1;
      state_d = SCAN;
    end
  end

  always_ff @(posedge cp or negedge rst_n) begin
    if (!rst_n) begin
      row_m_q   <= 4'hF;
      row_s_q   <= 4'hF;
      div_q     <= '0;
      state_q   <= SCAN;
      col_q     <= 2'd0;
      row_idx_q <= 2'd0;
      cnt_q     <= '0;
      code_q    <= 4'd0;
      valid_q   <= 1'b0;
      down_q    <= 1'b0;
    end else begin
      row_m_q   <= KEY_ROW;
      row_s_q   <= row_m_q;
      div_q     <= div_d;
      state_q   <= state_d;
      col_q     <= col_d;
      row_idx_q <= row_idx_d;
      cnt_q     <= cnt_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      down_q    <= down_d;
    end
  end

`ifdef KEY_REPEAT_EN
  always_ff @(posedge cp or negedge rst_n) begin
    if (!rst_n) rpt_q <= '0;
    else        rpt_q <= rpt_d;
  end
`endif

  assign KEY_COL          = ~(4'b0001 << col_q);
  assign key_if.key_code  = code_q;
  assign key_if.key_valid = valid_q;
  assign key_if.key_down  = down_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad matrix model with a key_code scoreboard.
// Expected codes are queued at press time; a monitor pops on key_valid.
module tb_keypad_scanner;

  logic        cp = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  key_row;
  logic [3:0]  key_col;
  logic [15:0] press;

  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  logic        prev_v = 1'b0;
  logic [3:0]  exp_q[$];
  int          pulse_t[$];

  keypad_scanner_if kif();

  keypad_scanner #(
    .CLK_DIV(4),
    .DEBOUNCE_TICKS(3)
`ifdef KEY_REPEAT_EN
    ,
    .REPEAT_DELAY(5),
    .REPEAT_RATE(2)
`endif
  ) dut (
    .cp(cp),
    .rst_n(rst_n),
    .KEY_ROW(key_row),
    .KEY_COL(key_col),
    .key_if(kif.master)
  );

  always #5 cp = ~cp;

  // pressed key at (r,c) pulls row r low while column c is driven low
  always_comb begin
    key_row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (press[r*4+c] && !key_col[c]) key_row[r] = 1'b0;
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(posedge cp) cyc <= cyc + 1;

  always @(negedge cp) begin
    logic [3:0] e;
    if (rst_n && kif.key_valid) begin
      check("kv_not_back_to_back", {31'd0, prev_v}, 32'd0);
      pulse_t.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_key_valid: got code %0h expected none",
                 kif.key_code);
      end else begin
        e = exp_q.pop_front();
        check("key_code", {28'd0, kif.key_code}, {28'd0, e});
      end
    end
    prev_v <= kif.key_valid;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic cycles(int n);
    repeat (n) @(negedge cp);
  endtask

  task automatic wait_down(logic lvl, int budget, string name,
                           output int took);
    took = 0;
    while (kif.key_down !== lvl && took < budget) begin
      @(negedge cp);
      took++;
    end
    check(name, {31'd0, kif.key_down}, {31'd0, lvl});
  endtask

  task automatic wait_col(logic [3:0] target, int budget, string name);
    int n;
    logic found;
    logic [3:0] prev;
    n = 0;
    found = 1'b0;
    prev = key_col;
    while (!found && n < budget) begin
      @(negedge cp);
      n++;
      if (key_col === target && prev !== target) found = 1'b1;
      prev = key_col;
    end
    check(name, {31'd0, found}, 32'd1);
  endtask

  task automatic check_reset_outs(string tag);
    check({tag, "_col"},   {28'd0, key_col},      32'hE);
    check({tag, "_code"},  {28'd0, kif.key_code}, 32'h0);
    check({tag, "_valid"}, {31'd0, kif.key_valid}, 32'd0);
    check({tag, "_down"},  {31'd0, kif.key_down},  32'd0);
  endtask

  initial begin
    int t;
    int gap;
    int changes;
    int g;
    logic dropped;
    logic [3:0] prev_col;
    logic [3:0] exp_col;

    press = '0;
    rst_n = 1'b0;
    cycles(3);
    check_reset_outs("reset");

    // idle scan: one column step every 4 cycles, no key events
    rst_n = 1'b1;
    prev_col = key_col;
    exp_col = 4'b1101;
    gap = 0;
    changes = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge cp);
      gap++;
      if (key_col !== prev_col) begin
        check("idle_col_seq", {28'd0, key_col}, {28'd0, exp_col});
        check("idle_col_period", gap, 4);
        prev_col = key_col;
        exp_col = {exp_col[2:0], exp_col[3]};
        gap = 0;
        changes++;
      end
    end
    check("idle_col_changes", changes, 16);

`ifndef KEY_REPEAT_EN
    // row 2 / col 1 press, hold, release
    press[2*4+1] = 1'b1;
    exp_q.push_back(4'b1001);
    wait_down(1'b1, 200, "press_down", t);
    check("press_col_frozen", {28'd0, key_col}, 32'hD);
    cycles(40);
    check("hold_down", {31'd0, kif.key_down}, 32'd1);
    check("hold_col_frozen", {28'd0, key_col}, 32'hD);
    press = '0;
    wait_down(1'b0, 40, "release_down", t);
    check("release_lat_min", {31'd0, t >= 11}, 32'd1);
    check("release_lat_max", {31'd0, t <= 14}, 32'd1);
    cycles(8);

    // bounce: row 0 low for two ticks in column 2
    wait_col(4'b1011, 40, "bounce_find_col2");
    press[0*4+2] = 1'b1;
    cycles(8);
    press = '0;
    g = 0;
    dropped = 1'b0;
    while (key_col === 4'b1011 && g < 20) begin
      @(negedge cp);
      g++;
      if (kif.key_down) dropped = 1'b1;
    end
    check("bounce_next_col", {28'd0, key_col}, 32'h7);
    check("bounce_freeze_len", g + 8, 12);
    check("bounce_no_down", {31'd0, dropped}, 32'd0);
    cycles(8);

    // one-tick high glitch during hold
    press[2*4+1] = 1'b1;
    exp_q.push_back(4'b1001);
    wait_down(1'b1, 200, "glitch_press_down", t);
    cycles(8);
    press = '0;
    cycles(4);
    press[2*4+1] = 1'b1;
    dropped = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge cp);
      if (!kif.key_down) dropped = 1'b1;
    end
    check("glitch_down_held", {31'd0, dropped}, 32'd0);
    check("glitch_col_frozen", {28'd0, key_col}, 32'hD);
    press = '0;
    wait_down(1'b0, 40, "glitch_release", t);
    cycles(8);

    // rows 1 and 3 in column 0, reset during hold
    press[1*4+0] = 1'b1;
    press[3*4+0] = 1'b1;
    exp_q.push_back(4'b0100);
    wait_down(1'b1, 200, "multi_press_down", t);
    check("multi_col_frozen", {28'd0, key_col}, 32'hE);
    cycles(8);
    rst_n = 1'b0;
    #1;
    check_reset_outs("midreset");
    cycles(3);
    exp_q.push_back(4'b0100);
    rst_n = 1'b1;
    wait_down(1'b1, 200, "redetect_down", t);
    check("redetect_col", {28'd0, key_col}, 32'hE);
    press = '0;
    wait_down(1'b0, 40, "redetect_release", t);
    cycles(8);
`else
    // auto-repeat: acceptance, +5 ticks, then every 2 ticks
    pulse_t.delete();
    press[2*4+1] = 1'b1;
    for (int i = 0; i < 9; i++) exp_q.push_back(4'b1001);
    t = 0;
    while (pulse_t.size() < 9 && t < 200) begin
      @(negedge cp);
      t++;
    end
    press = '0;
    check("rpt_count", pulse_t.size(), 9);
    if (pulse_t.size() == 9) begin
      check("rpt_first_gap", pulse_t[1] - pulse_t[0], 20);
      for (int i = 2; i < 9; i++)
        check("rpt_rate_gap", pulse_t[i] - pulse_t[i-1], 8);
    end
    wait_down(1'b0, 40, "rpt_release", t);
    cycles(20);
`endif

    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
